// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift, rotate, arithmetic shift and parallel load in
// either direction, plus a burst engine that runs exactly burst_len steps per start pulse.
module shift_reg_univ #(
  parameter int                 WIDTH   = 16,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic             d,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] out,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHIFT = 3'b001;
  localparam logic [2:0] MODE_ROT   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ARITH = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       bmode_q, bmode_d;
  logic             bdir_q, bdir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_ok;

  // One register step for a given operation; reserved codes fall through to hold.
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] cur,
    input logic [2:0]       op,
    input logic             right,
    input logic             fill,
    input logic [WIDTH-1:0] load_val
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      MODE_SHIFT: nxt = right ? {fill, cur[WIDTH-1:1]}       : {cur[WIDTH-2:0], fill};
      MODE_ROT:   nxt = right ? {cur[0], cur[WIDTH-1:1]}     : {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ARITH: nxt = right ? {cur[WIDTH-1], cur[WIDTH-1:1]} : {cur[WIDTH-2:0], 1'b0};
      MODE_LOAD:  nxt = load_val;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only the stepping modes can run a burst; load/hold/reserved with start are plain ops.
  assign start_ok = en && start &&
                    ((mode == MODE_SHIFT) || (mode == MODE_ROT) || (mode == MODE_ARITH));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    bmode_d = bmode_q;
    bdir_d  = bdir_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          bmode_d = mode;
          bdir_d  = dir;
          count_d = burst_len;
          state_d = (burst_len != '0) ? ST_RUN : ST_DONE;
        end else if (en) begin
          out_d = step(out_q, mode, dir, d, par_in);
        end
      end
      ST_RUN: begin
        if (en) begin
          out_d   = step(out_q, bmode_q, bdir_q, d, par_in);
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      out_q   <= RST_VAL;
      count_q <= '0;
      bmode_q <= MODE_HOLD;
      bdir_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      bmode_q <= bmode_d;
      bdir_q  <= bdir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out    = out_q;
  assign so_msb = out_q[WIDTH-1];
  assign so_lsb = out_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed testbench for shift_reg_univ (WIDTH=16, RST_VAL=0) with hand-computed expectations.
module tb_shift_reg_univ;

  localparam int WIDTH = 16;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [2:0]       mode;
  logic             dir;
  logic             d;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic [CW-1:0]    burst_len;
  logic [WIDTH-1:0] out;
  logic             so_msb;
  logic             so_lsb;
  logic             busy;
  logic             done;

  int tests_run = 0;
  int tests_failed = 0;

  shift_reg_univ #(.WIDTH(WIDTH), .RST_VAL(16'h0000)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .dir(dir), .d(d),
    .par_in(par_in), .start(start), .burst_len(burst_len),
    .out(out), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    en = 1'b1; start = 1'b0; mode = 3'b011; par_in = v;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b1; en = 1'b0; mode = 3'b000; dir = 1'b0; d = 1'b0;
    par_in = '0; start = 1'b0; burst_len = '0;
    tick(); tick();
    #3 rstn = 1'b0;
    #1;
    tests_run++;
    if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: out=%h busy=%b done=%b, want 0000 0 0", out, busy, done);
    end
    #1 rstn = 1'b1;
    en = 1'b0; mode = 3'b011; par_in = 16'hFFFF;
    tick(); tick();
    tests_run++;
    if (out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL en0_hold: out=%h want 0000", out);
    end
  endtask

  task automatic test_load_rotate();
    load(16'hA5C3);
    tests_run++;
    if (out !== 16'hA5C3 || so_msb !== 1'b1 || so_lsb !== 1'b1) begin
      tests_failed++;
      $display("FAIL load: out=%h msb=%b lsb=%b want a5c3 1 1", out, so_msb, so_lsb);
    end
    mode = 3'b010; dir = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (out !== 16'h5C3A || so_msb !== 1'b0 || so_lsb !== 1'b0) begin
      tests_failed++;
      $display("FAIL rot_left4: out=%h msb=%b lsb=%b want 5c3a 0 0", out, so_msb, so_lsb);
    end
    dir = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (out !== 16'hA5C3) begin
      tests_failed++;
      $display("FAIL rot_right4: out=%h want a5c3", out);
    end
  endtask

  task automatic test_shift_arith();
    load(16'h8001);
    mode = 3'b100; dir = 1'b1;
    tick();
    tests_run++;
    if (out !== 16'hC000) begin
      tests_failed++;
      $display("FAIL arith_right: out=%h want c000", out);
    end
    load(16'h8001);
    mode = 3'b100; dir = 1'b0;
    tick();
    tests_run++;
    if (out !== 16'h0002) begin
      tests_failed++;
      $display("FAIL arith_left: out=%h want 0002", out);
    end
    mode = 3'b001; dir = 1'b1; d = 1'b1;
    tick();
    tests_run++;
    if (out !== 16'h8001) begin
      tests_failed++;
      $display("FAIL shift_right_d1: out=%h want 8001", out);
    end
    mode = 3'b001; dir = 1'b0; d = 1'b1;
    tick();
    tests_run++;
    if (out !== 16'h0003) begin
      tests_failed++;
      $display("FAIL shift_left_d1: out=%h want 0003", out);
    end
    mode = 3'b101;
    tick();
    tests_run++;
    if (out !== 16'h0003) begin
      tests_failed++;
      $display("FAIL reserved_hold: out=%h want 0003", out);
    end
  endtask

  task automatic test_burst_shift();
    int busy_cycles, done_cycles, done_at;
    load(16'h0001);
    start = 1'b1; mode = 3'b001; dir = 1'b0; d = 1'b0; burst_len = CW'(5);
    tick();
    tests_run++;
    if (out !== 16'h0001 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_accept: out=%h busy=%b want 0001 1", out, busy);
    end
    // Live inputs must be ignored while the burst runs.
    start = 1'b0; mode = 3'b011; par_in = 16'hFFFF; dir = 1'b1;
    busy_cycles = 0; done_cycles = 0; done_at = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      busy_cycles++;
      if (done) begin
        done_cycles++;
        done_at = busy_cycles;
      end
      tick();
    end
    tests_run++;
    if (busy_cycles != 6 || done_cycles != 1 || done_at != 6) begin
      tests_failed++;
      $display("FAIL burst_timing: busy=%0d done=%0d at=%0d want 6 1 6",
               busy_cycles, done_cycles, done_at);
    end
    tests_run++;
    if (out !== 16'h0020) begin
      tests_failed++;
      $display("FAIL burst_result: out=%h want 0020", out);
    end
  endtask

  task automatic test_burst_pause();
    load(16'h8001);
    start = 1'b1; mode = 3'b010; dir = 1'b0; burst_len = CW'(3);
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    tests_run++;
    if (out !== 16'h0003 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_step1: out=%h busy=%b done=%b want 0003 1 0", out, busy, done);
    end
    en = 1'b0;
    tick(); tick();
    tests_run++;
    if (out !== 16'h0003 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_hold: out=%h busy=%b done=%b want 0003 1 0", out, busy, done);
    end
    en = 1'b1;
    tick();
    tests_run++;
    if (out !== 16'h0006 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_step2: out=%h done=%b want 0006 0", out, done);
    end
    tick();
    tests_run++;
    if (out !== 16'h000C || done !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_done: out=%h done=%b busy=%b want 000c 1 1", out, done, busy);
    end
    tick();
    tests_run++;
    if (out !== 16'h000C || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_idle: out=%h done=%b busy=%b want 000c 0 0", out, done, busy);
    end
    // Zero-length burst goes straight to DONE.
    start = 1'b1; mode = 3'b100; dir = 1'b0; burst_len = '0;
    tick();
    start = 1'b0; mode = 3'b000;
    tests_run++;
    if (out !== 16'h000C || done !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL len0_done: out=%h done=%b busy=%b want 000c 1 1", out, done, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_idle: done=%b busy=%b want 0 0", done, busy);
    end
    // Start with load mode is ignored; the load itself still happens.
    start = 1'b1; mode = 3'b011; par_in = 16'h1234; burst_len = CW'(4);
    tick();
    start = 1'b0; mode = 3'b000;
    tests_run++;
    if (out !== 16'h1234 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_load_ignored: out=%h busy=%b want 1234 0", out, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    load(16'h00FF);
    start = 1'b1; mode = 3'b001; dir = 1'b1; d = 1'b0; burst_len = CW'(8);
    tick();
    start = 1'b0;
    tick(); tick();
    tests_run++;
    if (out !== 16'h003F || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_progress: out=%h busy=%b want 003f 1", out, busy);
    end
    #3 rstn = 1'b0;
    #1;
    tests_run++;
    if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: out=%h busy=%b done=%b want 0000 0 0", out, busy, done);
    end
    #1 rstn = 1'b1;
    en = 1'b0; mode = 3'b000;
    tick();
    tests_run++;
    if (busy !== 1'b0 || out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL post_reset_idle: out=%h busy=%b want 0000 0", out, busy);
    end
    en = 1'b1; start = 1'b1; mode = 3'b001; dir = 1'b0; d = 1'b1; burst_len = CW'(2);
    tick();
    start = 1'b0; mode = 3'b000;
    tests_run++;
    if (out !== 16'h0000 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_accept: out=%h busy=%b want 0000 1", out, busy);
    end
    tick(); tick();
    tests_run++;
    if (out !== 16'h0003 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_done: out=%h done=%b want 0003 1", out, done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_rotate();
    test_shift_arith();
    test_burst_shift();
    test_burst_pause();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
